// File: rtl/mult_share_arbiter_if.sv
// Operand/result bundle for mult_share_arbiter.
// master: compute-client side (drives requests, consumes results).
// slave : arbiter side.
//   req_valid/req_ready : per-requester operand handshake
//   req_a/req_b         : packed operands, requester i at [i*BW +: BW]
//   res_valid/res_ready : shared result handshake
//   res_product/res_tag : unsigned product and issuing requester index
//   busy                : any request pending or result buffered
interface mult_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int BW_A    = 20,
    parameter int BW_B    = 40
);
    localparam int PW = BW_A + BW_B;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*BW_A-1:0] req_a;
    logic [NUM_REQ*BW_B-1:0] req_b;
    logic                    res_valid;
    logic                    res_ready;
    logic [PW-1:0]           res_product;
    logic [IDX_W-1:0]        res_tag;
    logic                    busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_product, res_tag, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_product, res_tag, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin shared multiplier. NUM_REQ requesters compete for one
// combinational unsigned multiplier; the granted product lands in a
// one-entry result buffer tagged with the requester index.
// Ports: clk, rst_n (async active-low), bus (mult_share_arbiter_if.slave).
// Build option: define MULT_SHARE_OPREG_EN to add an operand register
// stage ahead of the multiplier (latency 2, throughput still 1/cycle).
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int BW_A    = 20,
    parameter int BW_B    = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_share_arbiter_if.slave   bus
);
    localparam int PW = BW_A + BW_B;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, grant;
    logic             gnt_vld, can_issue, s2_accept, fire, load;
    logic [BW_A-1:0]  a_sel;
    logic [BW_B-1:0]  b_sel;
    logic [PW-1:0]    load_prod, prod_q;
    logic [IDX_W-1:0] load_tag, tag_q;
    logic             res_valid;
    logic             extra_busy;

    assign s2_accept = !res_valid || bus.res_ready;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        grant   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_vld && bus.req_valid[idx]) begin
                gnt_vld = 1'b1;
                grant   = IDX_W'(idx);
            end
        end
    end

    // rst_n gates the handshake so nothing is accepted while in reset.
    assign fire = rst_n && can_issue && gnt_vld;

    always_comb begin
        bus.req_ready = '0;
        if (fire) bus.req_ready[grant] = 1'b1;
    end

    assign a_sel = bus.req_a[grant*BW_A +: BW_A];
    assign b_sel = bus.req_b[grant*BW_B +: BW_B];

`ifdef MULT_SHARE_OPREG_EN
    logic             s1_vld;
    logic [BW_A-1:0]  s1_a;
    logic [BW_B-1:0]  s1_b;
    logic [IDX_W-1:0] s1_tag;

    assign can_issue  = !s1_vld || s2_accept;
    assign load       = s1_vld && s2_accept;
    assign load_prod  = PW'(s1_a) * PW'(s1_b);
    assign load_tag   = s1_tag;
    assign extra_busy = s1_vld;

    // Stage 1 advances only when it is empty or stage 2 takes its entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_tag <= '0;
        end else if (can_issue) begin
            s1_vld <= fire;
            if (fire) begin
                s1_a   <= a_sel;
                s1_b   <= b_sel;
                s1_tag <= grant;
            end
        end
    end
`else
    assign can_issue  = s2_accept;
    assign load       = fire;
    assign load_prod  = PW'(a_sel) * PW'(b_sel);
    assign load_tag   = grant;
    assign extra_busy = 1'b0;
`endif

    // Result buffer data and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            tag_q  <= '0;
            ptr    <= '0;
        end else begin
            if (load) begin
                prod_q <= load_prod;
                tag_q  <= load_tag;
            end
            if (fire)
                ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
        end
    end

    // Result buffer occupancy FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (load) state_nxt = FULL;
            FULL:  if (!load && bus.res_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        res_valid = (state == FULL);
    end

    assign bus.res_valid   = res_valid;
    assign bus.res_product = prod_q;
    assign bus.res_tag     = tag_q;
    assign bus.busy        = (|bus.req_valid) || res_valid || extra_busy;
endmodule
